// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: redirect control, instruction-memory request/response and decode handoff.
// fetch_fault exists only when FETCH_ALIGN_CHECK_EN is defined.
interface instr_fetch_unit_if;
   logic        redirect;
   logic [1:0]  pc_sel;
   logic [31:0] br_target;
   logic [31:0] jr_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        if_ready;
`ifdef FETCH_ALIGN_CHECK_EN
   logic        fetch_fault;
`endif

   modport master (
      input  redirect, pc_sel, br_target, jr_target,
      input  imem_gnt, imem_rvalid, imem_rdata, if_ready,
      output imem_req, imem_addr, if_valid, if_instr, if_pc
`ifdef FETCH_ALIGN_CHECK_EN
      , output fetch_fault
`endif
   );

   modport slave (
      output redirect, pc_sel, br_target, jr_target,
      output imem_gnt, imem_rvalid, imem_rdata, if_ready,
      input  imem_req, imem_addr, if_valid, if_instr, if_pc
`ifdef FETCH_ALIGN_CHECK_EN
      , input fetch_fault
`endif
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetch unit with redirect and response drain.
// Optional feature macro FETCH_ALIGN_CHECK_EN: misaligned redirect targets trap into FAULT.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h00000000
) (
   input  logic                 clk,
   input  logic                 rst,
   instr_fetch_unit_if.master   fif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_DRAIN
`ifdef FETCH_ALIGN_CHECK_EN
      , S_FAULT
`endif
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        if_valid_q, if_valid_d;
   logic [31:0] if_instr_q, if_instr_d;
   logic [31:0] if_pc_q, if_pc_d;
`ifdef FETCH_ALIGN_CHECK_EN
   logic        fault_q, fault_d;
   logic        misalign;
`endif

   logic [31:0] sel_target;
   logic [31:0] redir_tgt;
   logic        req;
   logic        grant;
   logic        capture;

   // Redirect target selection; pc+4 means "next after the instruction decode holds".
   always_comb begin
      sel_target = pc_q;
      case (fif.pc_sel)
         2'b00:   sel_target = if_valid_q ? (if_pc_q + 32'd4) : pc_q;
         2'b01:   sel_target = fif.br_target;
         2'b10:   sel_target = fif.jr_target;
         default: sel_target = 32'h0;
      endcase
   end

`ifdef FETCH_ALIGN_CHECK_EN
   assign redir_tgt = sel_target;
   assign misalign  = |sel_target[1:0];
`else
   assign redir_tgt = sel_target & ~32'h3;
`endif

   // Only request when decode has room, so a response can always be captured.
   assign req     = (state_q == S_REQ) && (!if_valid_q || fif.if_ready);
   assign grant   = req && fif.imem_gnt;
   assign capture = (state_q == S_WAIT) && fif.imem_rvalid && !fif.redirect;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      if_valid_d = if_valid_q;
      if_instr_d = if_instr_q;
      if_pc_d    = if_pc_q;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_d    = fault_q;
`endif

      if (if_valid_q && fif.if_ready) begin
         if_valid_d = 1'b0;
      end

      case (state_q)
         S_IDLE:  state_d = S_REQ;
         S_REQ:   if (grant) state_d = S_WAIT;
         S_WAIT:  if (fif.imem_rvalid) state_d = S_REQ;
         S_DRAIN: if (fif.imem_rvalid) state_d = S_REQ;
`ifdef FETCH_ALIGN_CHECK_EN
         S_FAULT: state_d = S_FAULT;
`endif
         default: state_d = S_IDLE;
      endcase

      if (capture) begin
         if_valid_d = 1'b1;
         if_instr_d = fif.imem_rdata;
         if_pc_d    = pc_q;
         pc_d       = pc_q + 32'd4;
      end

      // Redirect wins over capture; an in-flight response must be drained.
`ifdef FETCH_ALIGN_CHECK_EN
      if (fif.redirect && state_q != S_FAULT) begin
`else
      if (fif.redirect) begin
`endif
         if_valid_d = 1'b0;
         pc_d       = redir_tgt;
         case (state_q)
            S_IDLE,
            S_REQ:   state_d = grant ? S_DRAIN : S_REQ;
            S_WAIT:  state_d = fif.imem_rvalid ? S_REQ : S_DRAIN;
            S_DRAIN: state_d = fif.imem_rvalid ? S_REQ : S_DRAIN;
            default: state_d = S_IDLE;
         endcase
`ifdef FETCH_ALIGN_CHECK_EN
         if (misalign) begin
            pc_d    = pc_q;
            state_d = S_FAULT;
            fault_d = 1'b1;
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         if_valid_q <= 1'b0;
         if_instr_q <= 32'h0;
         if_pc_q    <= 32'h0;
`ifdef FETCH_ALIGN_CHECK_EN
         fault_q    <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         if_valid_q <= if_valid_d;
         if_instr_q <= if_instr_d;
         if_pc_q    <= if_pc_d;
`ifdef FETCH_ALIGN_CHECK_EN
         fault_q    <= fault_d;
`endif
      end
   end

   assign fif.imem_req  = req;
   assign fif.imem_addr = pc_q;
   assign fif.if_valid  = if_valid_q;
   assign fif.if_instr  = if_instr_q;
   assign fif.if_pc     = if_pc_q;
`ifdef FETCH_ALIGN_CHECK_EN
   assign fif.fetch_fault = fault_q;
`endif

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h00000000, PC value loaded on reset.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 redirect  in  1  apply pc_sel target this cycle.
REQ-005 pc_sel  in  2  00 = pc+4, 01 = br_target, 10 = jr_target, 11 = 32'h0.
REQ-006 br_target  in  32  branch target address.
REQ-007 jr_target  in  32  register-jump target address.
REQ-008 imem_req  out  1  instruction memory request.
REQ-009 imem_addr  out  32  request address, always equal to pc.
REQ-010 imem_gnt  in  1  memory accepts the request this cycle.
REQ-011 imem_rvalid  in  1  read data valid; at most one per granted request.
REQ-012 imem_rdata  in  32  instruction word.
REQ-013 if_valid  out  1  if_instr/if_pc valid for decode.
REQ-014 if_instr  out  32  fetched instruction.
REQ-015 if_pc  out  32  address of if_instr.
REQ-016 if_ready  in  1  decode consumes the output this cycle when if_valid=1.
REQ-017 fetch_fault  out  1  misaligned-target fault; present only under FETCH_ALIGN_CHECK_EN.

Function
REQ-018 The FSM SHALL have states IDLE, REQ, WAIT, DRAIN, plus FAULT when FETCH_ALIGN_CHECK_EN is defined.
REQ-019 IDLE SHALL move to REQ unconditionally on the next cycle.
REQ-020 In REQ, imem_req SHALL be 1 only when (!if_valid || if_ready). A grant in that cycle SHALL move the FSM to WAIT.
REQ-021 The block SHALL keep at most one request outstanding.
REQ-022 In WAIT, on imem_rvalid, the block SHALL load if_instr=imem_rdata, if_pc=pc and if_valid=1, SHALL set pc to pc+4 (32-bit wrap, carry discarded), and SHALL move to REQ.
REQ-023 if_valid SHALL clear on (if_valid && if_ready) unless it is reloaded in the same cycle.
REQ-024 if_instr and if_pc SHALL hold while (if_valid && !if_ready).
REQ-025 Minimum latency SHALL be 2 cycles from grant to if_valid with a 1-cycle memory; throughput SHALL be at most one instruction per 2 cycles.
REQ-026 A redirect SHALL load pc with the pc_sel selection, where 00 gives if_pc+4 if if_valid=1 and pc otherwise.
REQ-027 A redirect SHALL clear if_valid in the same edge.
REQ-028 Redirect in IDLE or in REQ without a grant SHALL go to REQ.
REQ-029 Redirect in REQ with a grant in the same cycle, or in WAIT without rvalid, SHALL go to DRAIN.
REQ-030 Redirect in WAIT with rvalid in the same cycle SHALL discard the response and go to REQ.
REQ-031 DRAIN SHALL keep imem_req=0, SHALL discard the next rvalid, and SHALL then go to REQ.
REQ-032 A redirect while in DRAIN SHALL update pc and stay in DRAIN.
REQ-033 Redirect SHALL take priority over response capture.

Reset
REQ-034 On rst=1 at a clock edge: pc=RESET_PC, state=IDLE, if_valid=0, if_instr=0, if_pc=0, imem_req=0, fetch_fault=0.
REQ-035 rst SHALL abandon any outstanding request, and the first rvalid seen after reset SHALL be discarded only if the FSM is in DRAIN.

Configuration
REQ-036 The feature macro SHALL be FETCH_ALIGN_CHECK_EN.
REQ-037 With FETCH_ALIGN_CHECK_EN defined, a redirect target with bits [1:0] != 00 SHALL set fetch_fault=1, enter FAULT, force imem_req=0 and if_valid=0, and hold FAULT until rst.
REQ-038 Without FETCH_ALIGN_CHECK_EN, the fetch_fault port and the FAULT state SHALL be absent, and target bits [1:0] SHALL be forced to 00.

Verification
REQ-039 Reset, then gnt=1 and rvalid 1 cycle later with rdata=32'hA0000001 -> if_valid=1, if_pc=0, if_instr=32'hA0000001, next imem_addr=4.
REQ-040 Hold if_ready=0 with if_valid=1 -> imem_req stays 0 and if_instr is held. Raise if_ready -> imem_req=1 in the same cycle.
REQ-041 redirect=1, pc_sel=01, br_target=32'h100 while in WAIT -> DRAIN. The next rvalid is dropped (if_valid stays 0), then imem_addr=32'h100.
REQ-042 redirect with pc_sel=11 at the same cycle as rvalid -> response discarded, state REQ, imem_addr=0.
REQ-043 With FETCH_ALIGN_CHECK_EN, redirect with pc_sel=10, jr_target=32'h102 -> fetch_fault=1 and imem_req stays 0 until rst.
REQ-044 pc=32'hFFFFFFFC, then capture -> next pc=0 (wrap).
